// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SPI-mode SD card responder.
package sd_spi_pkg;

  localparam logic [7:0] CMD0_IDX  = 8'h40;
  localparam logic [7:0] CMD1_IDX  = 8'h41;
  localparam logic [7:0] CMD17_IDX = 8'h51;

  localparam logic [7:0] R1_READY     = 8'h00;
  localparam logic [7:0] R1_IDLE      = 8'h01;
  localparam logic [7:0] R1_ILLEGAL   = 8'h04;
  localparam logic [7:0] R1_ILL_IDLE  = 8'h05;

  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] FILL_BYTE  = 8'hFF;

  localparam int SECTOR_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_RX,
    ST_RESP_GAP,
    ST_RESP,
    ST_DATA_GAP,
    ST_TOKEN,
    ST_DATA,
    ST_CRC
  } state_e;

endpackage

// File: rtl/spi_target_shifter.sv
// Oversampled SPI mode-0 target byte shifter: synchronisers, edge detect,
// bit counter and rx/tx shift registers. The next tx byte is taken on tx_load_o.
module spi_target_shifter (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       spi_cs_i,
  input  logic       spi_clk_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  input  logic [7:0] tx_byte_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       tx_load_o,
  output logic       cs_active_o
);
  import sd_spi_pkg::*;

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sh_q, rx_byte_q, tx_sh_q;
  logic       rx_valid_q, miso_q;
  logic       sclk_rise, sclk_fall;

  assign sclk_rise   = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_active_o = ~cs_sync_q[1];
  assign spi_miso_o  = miso_q;
  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign tx_load_o   = rx_valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_q <= 2'b11;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b11;
      sclk_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_clk_i};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  // Deselect holds the counter at zero, so a new select always starts on a byte boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q  <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= FILL_BYTE;
      miso_q     <= 1'b1;
    end else if (!cs_active_o) begin
      bit_cnt_q  <= 3'd0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= FILL_BYTE;
      miso_q     <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      if (sclk_rise) begin
        rx_sh_q   <= {rx_sh_q[6:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_q  <= {rx_sh_q[6:0], mosi_sync_q[1]};
          rx_valid_q <= 1'b1;
        end
      end
      if (rx_valid_q) begin
        tx_sh_q <= tx_byte_i;
      end else if (sclk_fall) begin
        miso_q  <= tx_sh_q[7];
        tx_sh_q <= {tx_sh_q[6:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card target answering CMD0, CMD1 and CMD17 single-block reads.
// The FSM state names the byte currently on the wire; tx_byte is what the next byte will be.
module sd_spi_responder #(
  parameter int NCR_BYTES      = 2,
  parameter int DATA_GAP_BYTES = 4,
  parameter int INIT_POLLS     = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        spi_cs_i,
  input  logic        spi_clk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic [23:0] mem_address_o,
  input  logic [7:0]  mem_data_i,
  output logic        card_ready_o,
  output logic        reading_o
);
  import sd_spi_pkg::*;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] arg_q, arg_d;
  logic [14:0] base_q, base_d;
  logic [8:0]  mem_idx_q, mem_idx_d;
  logic [7:0]  poll_q, poll_d;
  logic        idle_q, idle_d, ready_q, ready_d, reading_q, reading_d;

  logic [7:0]  rx_byte, tx_byte, r1_byte, r1_poll, poll_inc;
  logic        rx_valid, tx_load, cs_active, r1_idle, r1_ready;
  logic        enter_resp, enter_token;

  spi_target_shifter u_shifter (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .spi_cs_i    (spi_cs_i),
    .spi_clk_i   (spi_clk_i),
    .spi_mosi_i  (spi_mosi_i),
    .spi_miso_o  (spi_miso_o),
    .tx_byte_i   (tx_byte),
    .rx_byte_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .tx_load_o   (tx_load),
    .cs_active_o (cs_active)
  );

  assign mem_address_o = {base_q, mem_idx_q};
  assign card_ready_o  = ready_q;
  assign reading_o     = reading_q;
  assign poll_inc      = (poll_q == 8'hFF) ? poll_q : poll_q + 8'd1;

  always_comb begin
    r1_byte  = R1_ILLEGAL | {7'd0, idle_q};
    r1_idle  = idle_q;
    r1_ready = ready_q;
    r1_poll  = poll_q;
    case (cmd_q)
      CMD0_IDX: begin
        r1_idle  = 1'b1;
        r1_ready = 1'b0;
        r1_poll  = 8'd0;
        r1_byte  = R1_IDLE;
      end
      CMD1_IDX: begin
        if (idle_q) begin
          r1_poll = poll_inc;
          if (poll_inc >= 8'(INIT_POLLS)) begin
            r1_idle  = 1'b0;
            r1_ready = 1'b1;
            r1_byte  = R1_READY;
          end else begin
            r1_byte  = R1_IDLE;
          end
        end else begin
          r1_byte = R1_READY;
        end
      end
      CMD17_IDX: r1_byte = ready_q ? R1_READY : R1_ILL_IDLE;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    base_d      = base_q;
    mem_idx_d   = mem_idx_q;
    idle_d      = idle_q;
    ready_d     = ready_q;
    poll_d      = poll_q;
    reading_d   = reading_q;
    tx_byte     = FILL_BYTE;
    enter_resp  = 1'b0;
    enter_token = 1'b0;
    if (!cs_active) begin
      state_d   = ST_IDLE;
      reading_d = 1'b0;
    end else if (tx_load) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && rx_byte[7:6] == 2'b01) begin
            cmd_d   = rx_byte;
            cnt_d   = 4'd0;
            state_d = ST_CMD_RX;
          end
        end
        ST_CMD_RX: begin
          if (cnt_q != 4'd4) begin
            arg_d = {arg_q[15:0], rx_byte};
            cnt_d = cnt_q + 4'd1;
          end else begin
            if (cmd_q == CMD17_IDX) begin
              base_d    = arg_q[23:9];
              mem_idx_d = 9'd0;
            end
            if (NCR_BYTES == 1) begin
              enter_resp = 1'b1;
            end else begin
              state_d = ST_RESP_GAP;
              cnt_d   = 4'(NCR_BYTES - 1);
            end
          end
        end
        ST_RESP_GAP: begin
          if (cnt_q == 4'd1) enter_resp = 1'b1;
          else cnt_d = cnt_q - 4'd1;
        end
        ST_RESP: begin
          if (cmd_q == CMD17_IDX && ready_q) begin
            if (DATA_GAP_BYTES == 0) begin
              enter_token = 1'b1;
            end else begin
              state_d = ST_DATA_GAP;
              cnt_d   = 4'(DATA_GAP_BYTES);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA_GAP: begin
          if (cnt_q == 4'd1) enter_token = 1'b1;
          else cnt_d = cnt_q - 4'd1;
        end
        ST_TOKEN: begin
          state_d   = ST_DATA;
          tx_byte   = mem_data_i;
          mem_idx_d = mem_idx_q + 9'd1;
        end
        ST_DATA: begin
          // Index wraps to zero only after the last sector byte has been loaded.
          if (mem_idx_q == 9'd0) begin
            state_d = ST_CRC;
            cnt_d   = 4'd0;
          end else begin
            tx_byte   = mem_data_i;
            mem_idx_d = mem_idx_q + 9'd1;
          end
        end
        ST_CRC: begin
          if (cnt_q == 4'd1) begin
            state_d   = ST_IDLE;
            reading_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (enter_resp) begin
        state_d = ST_RESP;
        tx_byte = r1_byte;
        idle_d  = r1_idle;
        ready_d = r1_ready;
        poll_d  = r1_poll;
      end
      if (enter_token) begin
        state_d   = ST_TOKEN;
        tx_byte   = DATA_TOKEN;
        reading_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      cmd_q     <= 8'h00;
      arg_q     <= 24'd0;
      base_q    <= 15'd0;
      mem_idx_q <= 9'd0;
      idle_q    <= 1'b1;
      ready_q   <= 1'b0;
      poll_q    <= 8'd0;
      reading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      base_q    <= base_d;
      mem_idx_q <= mem_idx_d;
      idle_q    <= idle_d;
      ready_q   <= ready_d;
      poll_q    <= poll_d;
      reading_q <= reading_d;
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: drives an SPI host and a byte-wide sector memory.
module tb_sd_spi_responder;

  logic        clk, rst_n, spi_cs, spi_clk, spi_mosi, spi_miso;
  logic        card_ready, reading;
  logic [23:0] mem_address;
  logic [7:0]  mem_data;
  logic [7:0]  rx_buf [0:599];
  int          total = 0;
  int          bad = 0;
  int          addr_bad = 0;

  localparam logic [47:0] CMD0_FRAME  = 48'h40_00000000_95;
  localparam logic [47:0] CMD1_FRAME  = 48'h41_00000000_00;
  localparam logic [47:0] CMD17_FRAME = 48'h51_00012400_00;
  localparam logic [47:0] CMD8_FRAME  = 48'h48_000001AA_87;

  sd_spi_responder dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .spi_cs_i      (spi_cs),
    .spi_clk_i     (spi_clk),
    .spi_mosi_i    (spi_mosi),
    .spi_miso_o    (spi_miso),
    .mem_address_o (mem_address),
    .mem_data_i    (mem_data),
    .card_ready_o  (card_ready),
    .reading_o     (reading)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem_address[7:0] ^ 8'h5A;
  always @(posedge clk) if (reading && mem_address[23:9] != 15'h0092) addr_bad <= addr_bad + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      spi_clk  = 1'b0;
      spi_mosi = tx[b];
      #40;
      rx[b]    = spi_miso;
      spi_clk  = 1'b1;
      #40;
    end
  endtask

  task automatic xfer(input logic [47:0] cmd, input int nfill);
    logic [7:0] r;
    for (int i = 0; i < 6; i++) begin
      spi_byte(cmd[47-8*i -: 8], r);
      rx_buf[i] = r;
    end
    for (int i = 0; i < nfill; i++) begin
      spi_byte(8'hFF, r);
      rx_buf[6+i] = r;
    end
  endtask

  task automatic select_card();
    @(negedge clk);
    spi_cs = 1'b0;
    #100;
  endtask

  task automatic deselect_card();
    spi_cs = 1'b1;
    #100;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_cs = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b1;
    #32;
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL reset_miso got %b want 1", spi_miso); end
    total++; if (mem_address !== 24'h0) begin bad++; $display("FAIL reset_addr got %h want 000000", mem_address); end
    total++; if (card_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", card_ready); end
    total++; if (reading !== 1'b0) begin bad++; $display("FAIL reset_reading got %b want 0", reading); end
    @(negedge clk);
    rst_n = 1'b1;
    #50;
  endtask

  task automatic test_cmd17_not_ready();
    logic fe_seen;
    select_card();
    xfer(CMD17_FRAME, 42);
    total++; if (rx_buf[7] !== 8'h05) begin bad++; $display("FAIL nr_r1 got %h want 05", rx_buf[7]); end
    fe_seen = 1'b0;
    for (int i = 8; i < 48; i++) if (rx_buf[i] == 8'hFE) fe_seen = 1'b1;
    total++; if (fe_seen !== 1'b0) begin bad++; $display("FAIL nr_token got seen=%b want 0", fe_seen); end
    total++; if (reading !== 1'b0) begin bad++; $display("FAIL nr_reading got %b want 0", reading); end
    xfer(CMD8_FRAME, 2);
    total++; if (rx_buf[7] !== 8'h05) begin bad++; $display("FAIL cmd8_idle_r1 got %h want 05", rx_buf[7]); end
    deselect_card();
  endtask

  task automatic test_cmd0();
    select_card();
    xfer(CMD0_FRAME, 2);
    for (int i = 0; i < 7; i++) begin
      total++; if (rx_buf[i] !== 8'hFF) begin bad++; $display("FAIL cmd0_fill[%0d] got %h want ff", i, rx_buf[i]); end
    end
    total++; if (rx_buf[7] !== 8'h01) begin bad++; $display("FAIL cmd0_r1 got %h want 01", rx_buf[7]); end
    total++; if (card_ready !== 1'b0) begin bad++; $display("FAIL cmd0_ready got %b want 0", card_ready); end
    deselect_card();
  endtask

  task automatic test_cmd1();
    select_card();
    xfer(CMD1_FRAME, 2);
    total++; if (rx_buf[7] !== 8'h00) begin bad++; $display("FAIL cmd1_r1 got %h want 00", rx_buf[7]); end
    total++; if (card_ready !== 1'b1) begin bad++; $display("FAIL cmd1_ready got %b want 1", card_ready); end
    deselect_card();
  endtask

  task automatic test_read_block();
    logic [7:0] e;
    select_card();
    addr_bad = 0;
    xfer(CMD17_FRAME, 523);
    total++; if (rx_buf[7] !== 8'h00) begin bad++; $display("FAIL rd_r1 got %h want 00", rx_buf[7]); end
    for (int i = 8; i < 12; i++) begin
      total++; if (rx_buf[i] !== 8'hFF) begin bad++; $display("FAIL rd_gap[%0d] got %h want ff", i, rx_buf[i]); end
    end
    total++; if (rx_buf[12] !== 8'hFE) begin bad++; $display("FAIL rd_token got %h want fe", rx_buf[12]); end
    for (int i = 0; i < 512; i++) begin
      e = 8'(i) ^ 8'h5A;
      total++; if (rx_buf[13+i] !== e) begin bad++; $display("FAIL rd_data[%0d] got %h want %h", i, rx_buf[13+i], e); end
    end
    for (int i = 525; i < 529; i++) begin
      total++; if (rx_buf[i] !== 8'hFF) begin bad++; $display("FAIL rd_tail[%0d] got %h want ff", i, rx_buf[i]); end
    end
    total++; if (reading !== 1'b0) begin bad++; $display("FAIL rd_reading_end got %b want 0", reading); end
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL rd_addr_range got %0d stray cycles want 0", addr_bad); end
    xfer(CMD8_FRAME, 2);
    total++; if (rx_buf[7] !== 8'h04) begin bad++; $display("FAIL b2b_cmd8_r1 got %h want 04", rx_buf[7]); end
    deselect_card();
  endtask

  task automatic test_abort_restart();
    select_card();
    xfer(CMD17_FRAME, 107);
    total++; if (rx_buf[112] !== 8'h39) begin bad++; $display("FAIL ab_byte99 got %h want 39", rx_buf[112]); end
    total++; if (reading !== 1'b1) begin bad++; $display("FAIL ab_reading_pre got %b want 1", reading); end
    spi_cs = 1'b1;
    #40;
    total++; if (reading !== 1'b0) begin bad++; $display("FAIL ab_reading got %b want 0", reading); end
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL ab_miso got %b want 1", spi_miso); end
    #100;
    select_card();
    xfer(CMD17_FRAME, 11);
    total++; if (rx_buf[12] !== 8'hFE) begin bad++; $display("FAIL rs_token got %h want fe", rx_buf[12]); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rx_buf[13+i] !== (8'h5A ^ 8'(i))) begin bad++; $display("FAIL rs_data[%0d] got %h want %h", i, rx_buf[13+i], 8'h5A ^ 8'(i)); end
    end
    deselect_card();
  endtask

  task automatic test_reset_mid_data();
    select_card();
    xfer(CMD17_FRAME, 14);
    total++; if (reading !== 1'b1) begin bad++; $display("FAIL rm_reading_pre got %b want 1", reading); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (spi_miso !== 1'b1) begin bad++; $display("FAIL rm_miso got %b want 1", spi_miso); end
    total++; if (card_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got %b want 0", card_ready); end
    total++; if (reading !== 1'b0) begin bad++; $display("FAIL rm_reading got %b want 0", reading); end
    #29;
    rst_n = 1'b1;
    deselect_card();
  endtask

  initial begin
    test_reset();
    test_cmd17_not_ready();
    test_cmd0();
    test_cmd1();
    test_read_block();
    test_abort_restart();
    test_reset_mid_data();
    test_cmd0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
